// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DIGIT_W            - width of one packed BCD digit
//   IDLE/SHIFT/FINISH  - FSM state encodings
//   min_digits()       - smallest digit count that can hold 2^bin_w - 1
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // Smallest d with 10^d > 2^bin_w - 1, i.e. 10^d >= 2^bin_w.
    // The 128-bit accumulator covers any practical binary width.
    function automatic int min_digits(input int bin_w);
        logic [127:0] lim;
        logic [127:0] pow;
        int           d;
        lim = 128'd1 << bin_w;
        pow = 128'd1;
        d   = 0;
        while (pow < lim) begin
            pow = pow * 128'd10;
            d   = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary producer and the BCD converter.
// Latency: n/a (wiring only).
// Backpressure: none; requests raised while busy is high are dropped by the slave.
//
// Signals:
//   start   master->slave  request strobe, honoured only while busy=0
//   bin_in  master->slave  unsigned binary operand, sampled with an accepted start
//   busy    slave->master  conversion in progress
//   done    slave->master  one-cycle pulse, bcd_out just updated
//   bcd_out slave->master  packed BCD result, units digit in [3:0]
interface bin2bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);

    logic                      start;
    logic [BIN_W-1:0]          bin_in;
    logic                      busy;
    logic                      done;
    logic [DIGIT_W*DIGITS-1:0] bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );

endinterface

// File: rtl/bcd_add3_cell.sv
// Double-dabble digit adjust: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   din   4-bit BCD digit before adjust
//   dout  4-bit digit after adjust (codes 10..15 cannot arise in a
//         correctly sequenced converter and are forced to 0)
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = '0;
        if (din <= 4'd4) begin
            dout = din;
        end else if (din <= 4'd9) begin
            dout = din + 4'd3;
        end else begin
            // Not a BCD digit; flush to a known value rather than propagate garbage.
            dout = '0;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Latency: BIN_W shift cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is ignored while busy=1; a start during the done cycle is accepted.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts a conversion without a done pulse
//   bus  slave side of bin2bcd_seq_if (start/bin_in in, busy/done/bcd_out out)
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
)(
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Refuse to build a converter whose digit field cannot hold the largest input.
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    logic [1:0]       state_q,   state_d;
    logic [SCR_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [BCD_W-1:0] bcd_q,     bcd_d;

    // Scratch register after the per-digit add-3, and after the shift.
    logic [BCD_W-1:0] adj_bcd;
    logic [SCR_W-1:0] adj_scratch;
    logic [SCR_W-1:0] shl_scratch;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3_cell u_cell (
            .din  (scratch_q[BIN_W + DIGIT_W*i +: DIGIT_W]),
            .dout (adj_bcd[DIGIT_W*i +: DIGIT_W])
        );
    end

    // The digit count guarantees the MSB is never set by the adjust,
    // so nothing of value is shifted out.
    assign adj_scratch = {adj_bcd, scratch_q[BIN_W-1:0]};
    assign shl_scratch = adj_scratch << 1;

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;

        case (state_q)
            IDLE, FINISH: begin
                // FINISH behaves like IDLE for request acceptance so that
                // back-to-back conversions lose no cycle.
                if (bus.start) begin
                    scratch_d = {{BCD_W{1'b0}}, bus.bin_in};
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end

            SHIFT: begin
                scratch_d = shl_scratch;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    // Final shift: publish the digit field as it lands.
                    bcd_d   = shl_scratch[SCR_W-1 -: BCD_W];
                    state_d = FINISH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = (state_q == FINISH);
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: an 8-bit/3-digit instance and a 16-bit/5-digit instance.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_bin2bcd_seq;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) bus   ();
    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) bus16 ();

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge with start already driven; the next posedge accepts.
    // Returns edges counted from (and including) the accepting edge up to the
    // sample where done is seen.
    task automatic wait_done(input int limit, output int edges, output int busy_cnt,
                             output bit stable);
        logic [11:0] ref_v;
        ref_v = bus.bcd_out;
        @(negedge clk);
        bus.start = 1'b0;
        edges     = 1;
        busy_cnt  = 0;
        stable    = 1'b1;
        while (!bus.done && edges < limit) begin
            if (bus.busy) busy_cnt = busy_cnt + 1;
            if (bus.bcd_out !== ref_v) stable = 1'b0;
            @(negedge clk);
            edges = edges + 1;
        end
    endtask

    task automatic finish_checks(input string tag, input int edges, input int busy_cnt,
                                 input bit stable, input logic [11:0] exp);
        check({tag, "_latency"}, edges, 9);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_hold_before_done"}, {31'd0, stable}, 1);
        check({tag, "_value"}, bus.bcd_out, exp);
        check({tag, "_busy_in_finish"}, bus.busy, 0);
    endtask

    task automatic run_conv(input string tag, input logic [7:0] v, input logic [11:0] exp);
        int edges, busy_cnt;
        bit stable;
        bus.start  = 1'b1;
        bus.bin_in = v;
        wait_done(40, edges, busy_cnt, stable);
        finish_checks(tag, edges, busy_cnt, stable, exp);
        @(negedge clk);
        check({tag, "_done_width"}, bus.done, 0);
        check({tag, "_value_held"}, bus.bcd_out, exp);
    endtask

    task automatic run16(input string tag, input logic [15:0] v, input logic [19:0] exp);
        int edges;
        bus16.start  = 1'b1;
        bus16.bin_in = v;
        @(negedge clk);
        bus16.start = 1'b0;
        edges = 1;
        while (!bus16.done && edges < 60) begin
            @(negedge clk);
            edges = edges + 1;
        end
        check({tag, "_latency"}, edges, 17);
        check({tag, "_value"}, bus16.bcd_out, exp);
        @(negedge clk);
    endtask

    initial begin
        int edges, busy_cnt, n_done, done_edge;
        bit stable;

        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.bin_in   = '0;
        bus16.start  = 1'b0;
        bus16.bin_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_bcd",  bus.bcd_out, 0);
        check("rst_bcd16", bus16.bcd_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Maximum 8-bit value, then zero, then a two-digit value
        run_conv("c255", 8'd255, 12'h255);
        run_conv("c0",   8'd0,   12'h000);
        run_conv("c99",  8'd99,  12'h099);

        // Requests raised during the conversion are dropped
        bus.start  = 1'b1;
        bus.bin_in = 8'd7;
        @(negedge clk);
        edges     = 1;
        n_done    = 0;
        done_edge = 0;
        while (edges < 20) begin
            if (edges == 3 || edges == 5) begin
                bus.start  = 1'b1;
                bus.bin_in = 8'd200;
            end else begin
                bus.start  = 1'b0;
            end
            @(negedge clk);
            edges = edges + 1;
            if (bus.done) begin
                n_done    = n_done + 1;
                done_edge = edges;
            end
        end
        bus.start = 1'b0;
        check("ign_value",     bus.bcd_out, 12'h007);
        check("ign_done_cnt",  n_done, 1);
        check("ign_done_edge", done_edge, 9);
        check("ign_idle",      bus.busy, 0);

        // Back-to-back: new request accepted during the FINISH cycle
        bus.start  = 1'b1;
        bus.bin_in = 8'd128;
        wait_done(40, edges, busy_cnt, stable);
        finish_checks("b2b_first", edges, busy_cnt, stable, 12'h128);
        bus.start  = 1'b1;
        bus.bin_in = 8'd64;
        wait_done(40, edges, busy_cnt, stable);
        finish_checks("b2b_second", edges, busy_cnt, stable, 12'h064);
        @(negedge clk);
        check("b2b_done_width", bus.done, 0);

        // Reset partway through a conversion
        bus.start  = 1'b1;
        bus.bin_in = 8'd173;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_bcd",  bus.bcd_out, 0);
        check("abort_done", bus.done, 0);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) n_done = n_done + 1;
        end
        check("abort_no_done", n_done, 0);
        run_conv("c173", 8'd173, 12'h173);

        // Wider instance
        run16("w65535", 16'd65535, 20'h65535);
        run16("w0",     16'd0,     20'h00000);
        run16("w9999",  16'd9999,  20'h09999);
        run16("w10000", 16'd10000, 20'h10000);
        run16("w12345", 16'd12345, 20'h12345);
        run16("w40960", 16'd40960, 20'h40960);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
